// File: rtl/traceback_walker_pkg.sv
// Shared definitions for the NW traceback walker: direction codes and FSM states.
package traceback_walker_pkg;

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_LEFT = 2'b10;
    localparam logic [1:0] DIR_BAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STEP  = 3'd3,
        ST_EDGE  = 3'd4,
        ST_DONE  = 3'd5
    } tw_state_t;

    // Traceback owns the index muxes from FETCH through EDGE.
    function automatic logic is_busy(input tw_state_t s);
        return (s == ST_FETCH) || (s == ST_WAIT) || (s == ST_STEP) || (s == ST_EDGE);
    endfunction

endpackage

// File: rtl/traceback_walker.sv
// Walks the direction matrix from (N,N) to (0,0), addressing the direction RAM
// and emitting one alignment operation per step.
module traceback_walker
    import traceback_walker_pkg::*;
#(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         dir_data,
    output logic               dir_rd_en,
    output logic [BitAddr:0]   i_t,
    output logic [BitAddr:0]   j_t,
    output logic               en_traceA,
    output logic               en_traceB,
    output logic               change_index,
    output logic [1:0]         align_op,
    output logic               align_valid,
    output logic [BitAddr+1:0] align_len,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [BitAddr:0]   IDX_MAX = (BitAddr + 1)'(N);
    localparam logic [BitAddr:0]   IDX_ONE = (BitAddr + 1)'(1);
    localparam logic [BitAddr:0]   IDX_ZER = '0;
    localparam logic [BitAddr+1:0] LEN_ONE = (BitAddr + 2)'(1);

    tw_state_t          state, state_nx;
    logic [BitAddr:0]   i_q, j_q, i_nx, j_nx;
    logic [BitAddr+1:0] len_q, len_nx;
    logic               err_q, err_nx;
    logic [1:0]         dir_q;
    logic               busy_q;
    logic [1:0]         op;
    logic               op_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            i_q    <= '0;
            j_q    <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
            dir_q  <= DIR_DIAG;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            i_q    <= i_nx;
            j_q    <= j_nx;
            len_q  <= len_nx;
            err_q  <= err_nx;
            busy_q <= is_busy(state_nx);
            // RAM word is valid during WAIT; hold it for STEP.
            if (state == ST_WAIT) dir_q <= dir_data;
        end
    end

    always_comb begin
        state_nx = state;
        i_nx     = i_q;
        j_nx     = j_q;
        len_nx   = len_q;
        err_nx   = err_q;
        op       = DIR_DIAG;
        op_vld   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    i_nx     = IDX_MAX;
                    j_nx     = IDX_MAX;
                    len_nx   = '0;
                    err_nx   = 1'b0;
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: state_nx = ST_WAIT;
            ST_WAIT:  state_nx = ST_STEP;
            ST_STEP: begin
                if (dir_q == DIR_BAD) begin
                    err_nx   = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    op     = dir_q;
                    op_vld = 1'b1;
                    len_nx = len_q + LEN_ONE;
                    if (dir_q != DIR_LEFT && i_q != IDX_ZER) i_nx = i_q - IDX_ONE;
                    if (dir_q != DIR_UP && j_q != IDX_ZER)   j_nx = j_q - IDX_ONE;
                    if (i_nx == IDX_ZER && j_nx == IDX_ZER)      state_nx = ST_DONE;
                    else if (i_nx == IDX_ZER || j_nx == IDX_ZER) state_nx = ST_EDGE;
                    else                                         state_nx = ST_FETCH;
                end
            end
            ST_EDGE: begin
                // One border is reached; the rest of the path is forced.
                op_vld = 1'b1;
                len_nx = len_q + LEN_ONE;
                if (i_q == IDX_ZER) begin
                    op = DIR_LEFT;
                    if (j_q != IDX_ZER) j_nx = j_q - IDX_ONE;
                end else begin
                    op   = DIR_UP;
                    i_nx = i_q - IDX_ONE;
                end
                if (i_nx == IDX_ZER && j_nx == IDX_ZER) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign dir_rd_en    = (state == ST_FETCH);
    assign i_t          = i_q;
    assign j_t          = j_q;
    assign align_len    = len_q;
    assign err          = err_q;
    assign align_op     = op;
    assign align_valid  = op_vld;
    assign busy         = busy_q;
    assign en_traceA    = busy_q;
    assign en_traceB    = busy_q;
    assign change_index = busy_q;
    assign done         = (state == ST_DONE);

endmodule
